// File: rtl/encoder_accumulator.sv
// Bounded up/down value driven by encoder detent pulses, with speed-dependent acceleration.
// Value_o/Changed_o/Fast_o update one cycle after the sampled event or load; no backpressure, every pulse is consumed.
module encoder_accumulator #(
    parameter int CLOCK_HZ       = 10_000_000,
    parameter int WIDTH          = 8,
    parameter int MIN_VALUE      = 0,
    parameter int MAX_VALUE      = 99,
    parameter int INIT_VALUE     = 0,
    parameter int WRAP           = 0,
    parameter int FAST_WINDOW_US = 20_000,
    parameter int FAST_THRESHOLD = 4,
    parameter int FAST_STEP      = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Increment_i,
    input  logic             Decrement_i,
    input  logic             Load_i,
    input  logic [WIDTH-1:0] Data_i,
    output logic [WIDTH-1:0] Value_o,
    output logic             Changed_o,
    output logic             Fast_o
);

    localparam int WINDOW_CLOCKS = CLOCK_HZ / 1_000_000 * FAST_WINDOW_US;
    localparam int TW = $clog2(WINDOW_CLOCKS + 1);
    localparam int SW = $clog2(FAST_THRESHOLD + 1);

    localparam logic [TW-1:0]  L_WC    = TW'(WINDOW_CLOCKS);
    localparam logic [SW-1:0]  L_THR   = SW'(FAST_THRESHOLD);
    localparam logic [WIDTH:0] L_MIN   = (WIDTH+1)'(MIN_VALUE);
    localparam logic [WIDTH:0] L_MAX   = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0] L_RANGE = (WIDTH+1)'(MAX_VALUE - MIN_VALUE + 1);
    localparam logic [WIDTH:0] L_FSTEP = (WIDTH+1)'(FAST_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_FAST
    } state_t;

    state_t           r_state;
    logic [SW-1:0]    r_streak;
    logic             r_dir;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_value;
    logic             r_changed;
    logic             r_fast;

    state_t           w_state_nxt;
    logic [SW-1:0]    w_streak_nxt;
    logic             w_dir_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [WIDTH-1:0] w_value_nxt;

    logic             w_event;
    logic             w_up;
    logic             w_quick;
    logic             w_fast_step;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_base;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_low;
    logic [WIDTH-1:0] w_step_res;
    logic [WIDTH-1:0] w_load_val;

    // Both pulses in one cycle cancel out and leave all tracking untouched.
    assign w_event = Increment_i ^ Decrement_i;
    assign w_up    = Increment_i;
    assign w_quick = w_event && (r_state != S_IDLE) && (r_timer < L_WC) && (w_up == r_dir);

    always_comb begin
        w_fast_step = 1'b0;
        if (w_quick) begin
            w_fast_step = (r_state == S_FAST) || ((r_streak + SW'(1)) >= L_THR);
        end
    end

    // One extra bit of headroom keeps value+step and MIN+step from overflowing.
    always_comb begin
        w_step     = w_fast_step ? L_FSTEP : (WIDTH+1)'(1);
        w_base     = {1'b0, r_value};
        w_sum      = w_base + w_step;
        w_low      = L_MIN + w_step;
        w_step_res = r_value;
        if (w_up) begin
            if (w_sum > L_MAX) begin
                w_step_res = (WRAP != 0) ? WIDTH'(w_sum - L_RANGE) : WIDTH'(L_MAX);
            end else begin
                w_step_res = WIDTH'(w_sum);
            end
        end else begin
            if (w_base < w_low) begin
                w_step_res = (WRAP != 0) ? WIDTH'(w_base + L_RANGE - w_step) : WIDTH'(L_MIN);
            end else begin
                w_step_res = WIDTH'(w_base - w_step);
            end
        end
    end

    always_comb begin
        w_load_val = Data_i;
        if (int'(Data_i) < MIN_VALUE) begin
            w_load_val = WIDTH'(MIN_VALUE);
        end else if (int'(Data_i) > MAX_VALUE) begin
            w_load_val = WIDTH'(MAX_VALUE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_dir_nxt    = r_dir;
        w_timer_nxt  = (r_timer == L_WC) ? r_timer : r_timer + TW'(1);
        w_value_nxt  = r_value;
        if (Load_i) begin
            w_state_nxt  = S_IDLE;
            w_streak_nxt = '0;
            w_timer_nxt  = '0;
            w_value_nxt  = w_load_val;
        end else if (w_event) begin
            w_timer_nxt = '0;
            w_dir_nxt   = w_up;
            w_value_nxt = w_step_res;
            if (!w_quick) begin
                w_state_nxt  = S_TRACK;
                w_streak_nxt = SW'(1);
            end else if (r_state != S_FAST) begin
                if (w_fast_step) begin
                    w_state_nxt  = S_FAST;
                    w_streak_nxt = L_THR;
                end else begin
                    w_streak_nxt = r_streak + SW'(1);
                end
            end
        end else if ((r_timer == L_WC) && (r_state != S_IDLE)) begin
            w_state_nxt  = S_IDLE;
            w_streak_nxt = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_streak  <= '0;
            r_dir     <= 1'b0;
            r_timer   <= L_WC;
            r_value   <= WIDTH'(INIT_VALUE);
            r_changed <= 1'b0;
            r_fast    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_streak  <= w_streak_nxt;
            r_dir     <= w_dir_nxt;
            r_timer   <= w_timer_nxt;
            r_value   <= w_value_nxt;
            r_changed <= (w_value_nxt != r_value);
            r_fast    <= (w_state_nxt == S_FAST);
        end
    end

    assign Value_o   = r_value;
    assign Changed_o = r_changed;
    assign Fast_o    = r_fast;

endmodule

// File: tb/tb_encoder_accumulator.sv
// Checks a saturating and a wrapping encoder_accumulator side by side against an event-history model.
module tb_encoder_accumulator;

    localparam int WC   = 100;
    localparam int THR  = 4;
    localparam int FS   = 10;
    localparam int MINV = 0;
    localparam int MAXV = 99;
    localparam int INIT = 0;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       inc, dec, ld;
    logic [7:0] din;
    logic [7:0] val0, val1;
    logic       chg0, chg1, fast0, fast1;

    int checks   = 0;
    int failures = 0;

    // Model: value per DUT, plus shared detent history (time of last event, direction, streak).
    int m_val [2];
    bit m_chg [2];
    bit m_hist;
    bit m_dir;
    int m_last;
    int m_streak;
    int n_edge = 0;

    always #5 Clock = ~Clock;

    encoder_accumulator #(
        .CLOCK_HZ(10_000_000), .WIDTH(8), .MIN_VALUE(MINV), .MAX_VALUE(MAXV),
        .INIT_VALUE(INIT), .WRAP(0), .FAST_WINDOW_US(10), .FAST_THRESHOLD(THR), .FAST_STEP(FS)
    ) u_sat (
        .Clock(Clock), .Reset(Reset), .Increment_i(inc), .Decrement_i(dec),
        .Load_i(ld), .Data_i(din), .Value_o(val0), .Changed_o(chg0), .Fast_o(fast0)
    );

    encoder_accumulator #(
        .CLOCK_HZ(10_000_000), .WIDTH(8), .MIN_VALUE(MINV), .MAX_VALUE(MAXV),
        .INIT_VALUE(INIT), .WRAP(1), .FAST_WINDOW_US(10), .FAST_THRESHOLD(THR), .FAST_STEP(FS)
    ) u_wrap (
        .Clock(Clock), .Reset(Reset), .Increment_i(inc), .Decrement_i(dec),
        .Load_i(ld), .Data_i(din), .Value_o(val1), .Changed_o(chg1), .Fast_o(fast1)
    );

    function automatic int m_apply(int v, int delta, bit wrap);
        int r = v + delta;
        if (wrap) begin
            while (r > MAXV) r -= (MAXV - MINV + 1);
            while (r < MINV) r += (MAXV - MINV + 1);
        end else begin
            if (r > MAXV) r = MAXV;
            if (r < MINV) r = MINV;
        end
        return r;
    endfunction

    function automatic bit m_fast();
        return m_hist && (m_streak >= THR) && ((n_edge - m_last) <= WC);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = INIT;
            m_chg[k] = 1'b0;
        end
        m_hist   = 1'b0;
        m_streak = 0;
    endtask

    task automatic model_edge(input bit i, input bit d, input bit l, input int data);
        int  c, step, nv;
        bit  q;
        n_edge++;
        if (l) begin
            c = (data > MAXV) ? MAXV : ((data < MINV) ? MINV : data);
            for (int k = 0; k < 2; k++) begin
                m_chg[k] = (c != m_val[k]);
                m_val[k] = c;
            end
            m_hist   = 1'b0;
            m_streak = 0;
        end else if (i != d) begin
            q = m_hist && ((n_edge - m_last) <= WC) && (i == m_dir);
            m_streak = q ? ((m_streak + 1 > THR) ? THR : m_streak + 1) : 1;
            step = (q && m_streak >= THR) ? FS : 1;
            for (int k = 0; k < 2; k++) begin
                nv = m_apply(m_val[k], i ? step : -step, k == 1);
                m_chg[k] = (nv != m_val[k]);
                m_val[k] = nv;
            end
            m_hist = 1'b1;
            m_dir  = i;
            m_last = n_edge;
        end else begin
            m_chg[0] = 1'b0;
            m_chg[1] = 1'b0;
        end
    endtask

    task automatic tick(input bit i, input bit d, input bit l, input logic [7:0] data);
        inc = i; dec = d; ld = l; din = data;
        @(posedge Clock);
        model_edge(i, d, l, int'(data));
        #1;
        inc = 1'b0; dec = 1'b0; ld = 1'b0; din = 8'd0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (val0 !== 8'd0 || chg0 !== 1'b0 || fast0 !== 1'b0 || val1 !== 8'd0 || chg1 !== 1'b0 || fast1 !== 1'b0) begin
            failures++;
            $display("FAIL reset got val=%0d/%0d chg=%b/%b fast=%b/%b want 0/0 0/0 0/0", val0, val1, chg0, chg1, fast0, fast1);
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_inc();
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd1 || chg0 !== 1'b1 || fast0 !== 1'b0) begin
            failures++;
            $display("FAIL single_inc got val=%0d chg=%b fast=%b want 1 1 0", val0, chg0, fast0);
        end
        idle(1);
        checks++;
        if (val0 !== 8'd1 || chg0 !== 1'b0) begin
            failures++;
            $display("FAIL single_inc_pulse got val=%0d chg=%b want 1 0", val0, chg0);
        end
    endtask

    task automatic test_bounds();
        idle(150);
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        tick(1'b0, 1'b1, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd0 || chg0 !== 1'b0) begin
            failures++;
            $display("FAIL sat_low got val=%0d chg=%b want 0 0", val0, chg0);
        end
        checks++;
        if (val1 !== 8'd99 || chg1 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_low got val=%0d chg=%b want 99 1", val1, chg1);
        end
        tick(1'b0, 1'b0, 1'b1, 8'd99);
        checks++;
        if (chg1 !== 1'b0 || chg0 !== 1'b1) begin
            failures++;
            $display("FAIL load_same got chg_wrap=%b chg_sat=%b want 0 1", chg1, chg0);
        end
        idle(150);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd99 || chg0 !== 1'b0) begin
            failures++;
            $display("FAIL sat_high got val=%0d chg=%b want 99 0", val0, chg0);
        end
        checks++;
        if (val1 !== 8'd0 || chg1 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_high got val=%0d chg=%b want 0 1", val1, chg1);
        end
    endtask

    task automatic test_accel();
        int  exp_v [6] = '{1, 2, 3, 13, 23, 33};
        bit  exp_f [6] = '{0, 0, 0, 1, 1, 1};
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        for (int e = 0; e < 6; e++) begin
            idle(49);
            tick(1'b1, 1'b0, 1'b0, 8'd0);
            checks++;
            if (int'(val0) != exp_v[e] || fast0 !== exp_f[e] || chg0 !== 1'b1) begin
                failures++;
                $display("FAIL accel[%0d] got val=%0d fast=%b chg=%b want %0d %b 1", e, val0, fast0, chg0, exp_v[e], exp_f[e]);
            end
        end
        idle(100);
        checks++;
        if (fast0 !== 1'b1) begin
            failures++;
            $display("FAIL fast_hold got fast=%b want 1", fast0);
        end
        idle(1);
        checks++;
        if (fast0 !== 1'b0) begin
            failures++;
            $display("FAIL fast_drop got fast=%b want 0", fast0);
        end
        idle(49);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd34 || fast0 !== 1'b0) begin
            failures++;
            $display("FAIL after_idle got val=%0d fast=%b want 34 0", val0, fast0);
        end
    endtask

    task automatic test_window_edge();
        int exp_v [4] = '{1, 2, 3, 13};
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) idle(99);
            tick(1'b1, 1'b0, 1'b0, 8'd0);
            checks++;
            if (int'(val0) != exp_v[e]) begin
                failures++;
                $display("FAIL window_edge[%0d] got val=%0d want %0d", e, val0, exp_v[e]);
            end
        end
        idle(100);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd14 || fast0 !== 1'b0) begin
            failures++;
            $display("FAIL window_late got val=%0d fast=%b want 14 0", val0, fast0);
        end
    endtask

    task automatic test_dir_change();
        int exp_v [3] = '{11, 10, 0};
        bit exp_f [3] = '{0, 0, 1};
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) idle(9);
            tick(1'b1, 1'b0, 1'b0, 8'd0);
        end
        idle(49);
        tick(1'b0, 1'b1, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd12 || fast0 !== 1'b0) begin
            failures++;
            $display("FAIL dir_change got val=%0d fast=%b want 12 0", val0, fast0);
        end
        for (int e = 0; e < 3; e++) begin
            idle(9);
            tick(1'b0, 1'b1, 1'b0, 8'd0);
            checks++;
            if (int'(val0) != exp_v[e] || fast0 !== exp_f[e]) begin
                failures++;
                $display("FAIL dir_dec[%0d] got val=%0d fast=%b want %0d %b", e, val0, fast0, exp_v[e], exp_f[e]);
            end
        end
    endtask

    task automatic test_wrap_fast();
        tick(1'b0, 1'b0, 1'b1, 8'd83);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) idle(9);
            tick(1'b1, 1'b0, 1'b0, 8'd0);
        end
        checks++;
        if (val1 !== 8'd96 || fast1 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_enter_fast got val=%0d fast=%b want 96 1", val1, fast1);
        end
        idle(9);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (val1 !== 8'd6 || val0 !== 8'd99) begin
            failures++;
            $display("FAIL fast_overshoot got wrap=%0d sat=%0d want 6 99", val1, val0);
        end
    endtask

    task automatic test_both_and_load();
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        tick(1'b1, 1'b1, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd0 || chg0 !== 1'b0) begin
            failures++;
            $display("FAIL both_pulses got val=%0d chg=%b want 0 0", val0, chg0);
        end
        tick(1'b0, 1'b0, 1'b1, 8'd150);
        checks++;
        if (val0 !== 8'd99 || chg0 !== 1'b1) begin
            failures++;
            $display("FAIL load_clamp got val=%0d chg=%b want 99 1", val0, chg0);
        end
        tick(1'b0, 1'b0, 1'b1, 8'd99);
        checks++;
        if (val0 !== 8'd99 || chg0 !== 1'b0) begin
            failures++;
            $display("FAIL load_identical got val=%0d chg=%b want 99 0", val0, chg0);
        end
        tick(1'b1, 1'b0, 1'b1, 8'd40);
        checks++;
        if (val0 !== 8'd40 || chg0 !== 1'b1) begin
            failures++;
            $display("FAIL load_priority got val=%0d chg=%b want 40 1", val0, chg0);
        end
    endtask

    task automatic test_back_to_back();
        int exp_v [6] = '{1, 2, 3, 13, 23, 33};
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        for (int e = 0; e < 6; e++) begin
            tick(1'b1, 1'b0, 1'b0, 8'd0);
            checks++;
            if (int'(val0) != exp_v[e] || chg0 !== 1'b1 || fast0 !== (e >= 3)) begin
                failures++;
                $display("FAIL back_to_back[%0d] got val=%0d chg=%b fast=%b want %0d 1 %b", e, val0, chg0, fast0, exp_v[e], e >= 3);
            end
        end
    endtask

    task automatic test_reset_mid_fast();
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) idle(9);
            tick(1'b1, 1'b0, 1'b0, 8'd0);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (val0 !== 8'd0 || fast0 !== 1'b0 || chg0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got val=%0d fast=%b chg=%b want 0 0 0", val0, fast0, chg0);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
        idle(3);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        idle(3);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (val0 !== 8'd2 || fast0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart got val=%0d fast=%b want 2 0", val0, fast0);
        end
    endtask

    task automatic test_random();
        int         gap_left = 0;
        int         r;
        bit         dir = 1'b1;
        logic [7:0] d;
        logic [7:0] v;
        logic       c, f;
        for (int n = 0; n < 5000; n++) begin
            if (gap_left > 0) begin
                gap_left--;
                idle(1);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    d = 8'($urandom_range(0, 255));
                    tick(1'($urandom_range(0, 1)), 1'b0, 1'b1, d);
                end else if (r < 6) begin
                    tick(1'b1, 1'b1, 1'b0, 8'd0);
                end else begin
                    if ($urandom_range(0, 9) < 2) dir = ~dir;
                    tick(dir, ~dir, 1'b0, 8'd0);
                end
                gap_left = ($urandom_range(0, 4) == 0) ? $urandom_range(90, 130) : $urandom_range(0, 40);
            end
            for (int k = 0; k < 2; k++) begin
                v = (k == 0) ? val0 : val1;
                c = (k == 0) ? chg0 : chg1;
                f = (k == 0) ? fast0 : fast1;
                checks++;
                if (int'(v) != m_val[k] || c !== m_chg[k] || f !== m_fast()) begin
                    failures++;
                    $display("FAIL random dut%0d edge=%0d got val=%0d chg=%b fast=%b want %0d %b %b",
                             k, n_edge, v, c, f, m_val[k], m_chg[k], m_fast());
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        inc   = 1'b0;
        dec   = 1'b0;
        ld    = 1'b0;
        din   = 8'd0;
        model_reset();
        test_reset();
        test_single_inc();
        test_bounds();
        test_accel();
        test_window_edge();
        test_dir_change();
        test_wrap_fast();
        test_both_and_load();
        test_back_to_back();
        test_reset_mid_fast();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
